gray_arb: RTL and testbench
===========================

GRAY_ARB -- requirements
Module: gray_arb

Interface
REQ-001 SHALL have ports: clk  input  1  the single clock; every register updates on its rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have ports: req0 / req1  input  1  read request from requester 0 / 1.
REQ-004 SHALL have ports: addr0 / addr1  input  14  read address from requester 0 / 1, as {row[6:0], col[6:0]}.
REQ-005 SHALL have ports: lock0 / lock1  input  1  the requester asks to keep its grant across gaps in req.
REQ-006 SHALL have ports: gnt0 / gnt1  output  1  registered grant; at most one is high in any cycle.
REQ-007 SHALL have ports: rvalid0 / rvalid1  output  1  registered read-data strobe for requester 0 / 1.
REQ-008 SHALL have ports: rdata  output  8  registered read data, shared by both requesters.
REQ-009 SHALL have ports: mem_rd  output  1  registered read strobe to the gray memory.
REQ-010 SHALL have ports: mem_addr  output  14  registered read address to the gray memory.
REQ-011 SHALL have ports: mem_data  input  8  memory read data, valid in the same cycle as mem_rd.
REQ-012 SHALL have ports: busy  output  1  high in cycles where the state is OWN0 or OWN1, or any read is still in flight.

Function
REQ-013 SHALL implement three states: IDLE, OWN0 and OWN1.
- gnt0 = (state == OWN0).
- gnt1 = (state == OWN1).
- Both grants are driven from the state register.
REQ-014 SHALL, in IDLE with exactly one req high, move to that requester's OWN state on the next edge.
REQ-015 SHALL, in IDLE with both req high, grant the requester that is not last_owner (round-robin); last_owner updates on every IDLE->OWN transition.
REQ-016 SHALL stay in IDLE when both req are low; lock inputs are ignored in IDLE.
REQ-017 SHALL accept one beat in each cycle where state == OWNi and reqi == 1; addri is captured in that cycle.
REQ-018 SHALL, for a beat accepted in cycle A:
- drive mem_rd = 1 and mem_addr = addri during cycle A+1;
- drive rvalidi = 1 and rdata = the mem_data value from cycle A+1 during cycle A+2.
- Read latency is therefore fixed at 2 cycles.
REQ-019 SHALL hold mem_rd low in cycles with no beat from the previous cycle; mem_addr holds its last value.
REQ-020 SHALL hold rvalid0 and rvalid1 low except as in REQ-018; they are never both high; rdata holds its value when neither is high.
REQ-021 SHALL keep a 5-bit beat counter.
- Clears on entry to OWN0 or OWN1.
- Increments per accepted beat.
- Saturates at 16.
REQ-022 SHALL return from OWNi to IDLE at the next edge when (reqi == 0 and locki == 0), or when (beat count == 16 and the other req == 1).
REQ-023 SHALL keep the OWN state while locki == 1 and reqi == 0; no beats are accepted in those cycles.
REQ-024 SHALL insert at least one IDLE cycle between two ownerships, so no gnt is high in that cycle.
REQ-025 SHALL still deliver the rvalid and rdata of beats already accepted after a grant is released (in-flight reads complete).
REQ-026 SHALL force a release at 16 beats even when locki == 1, provided the other requester is requesting.
REQ-027 SHALL let an owner that is alone continue past 16 beats.

Reset
REQ-028 SHALL, when reset is high at a rising edge, set:
- state = IDLE;
- last_owner = 1 (so requester 0 wins the first tie);
- beat counter = 0;
- gnt0, gnt1, rvalid0, rvalid1, mem_rd and busy = 0;
- mem_addr = 0 and rdata = 0.
REQ-029 SHALL discard in-flight reads on reset; no rvalid is asserted in the cycle after the reset is released.
REQ-030 SHALL give reset priority over every other input in the same cycle.

Verification
REQ-031 SHALL cover: after reset, req0 = req1 = 1 in the same cycle -> gnt0 = 1 the next cycle, gnt1 = 0.
REQ-032 SHALL cover: req0 held with addr0 = 0x0081 accepted in cycle A, mem_data = 0x5A in A+1 -> mem_rd = 1 and mem_addr = 0x0081 in A+1; rvalid0 = 1 and rdata = 0x5A in A+2.
REQ-033 SHALL cover: OWN0 with lock0 = 1 and req1 = 1 continuously -> exactly 16 beats for requester 0, then one IDLE cycle, then gnt1 = 1.
REQ-034 SHALL cover: req0 alone for 20 cycles with lock0 = 0 -> 20 beats with no release; req0 then drops -> IDLE on the next edge while the last two rvalid0 pulses still arrive.
REQ-035 SHALL cover: lock1 = 1 and req1 = 0 for 5 cycles while in OWN1 -> gnt1 stays 1, mem_rd stays 0, and req0 gets no grant.
REQ-036 SHALL cover: reset asserted one cycle after a beat is accepted -> all outputs 0 the following cycle, and no rvalid appears afterwards.

Source files
------------

// File: rtl/gray_arb.sv
// gray_arb: two-requester round-robin arbiter in front of a gray-level memory with a fixed 2-cycle read pipeline
//   clk                 rising-edge clock
//   reset               synchronous active-high reset
//   req0/req1           read request per requester
//   addr0/addr1 [13:0]  read address {row, col} per requester
//   lock0/lock1         keep the grant across gaps in req
//   gnt0/gnt1           registered grant (one-hot or zero)
//   rvalid0/rvalid1     read-data strobe per requester
//   rdata [7:0]         shared read data
//   mem_rd, mem_addr    read strobe and address to the memory
//   mem_data [7:0]      memory data, valid with mem_rd
//   busy                owned, or a read still in flight
module gray_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [13:0] addr0,
    input  logic [13:0] addr1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [7:0]  mem_data,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [7:0]  rdata,
    output logic        mem_rd,
    output logic [13:0] mem_addr,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    logic [1:0] state, state_nx;
    logic       last_owner;
    logic [4:0] cnt;
    logic       rd_id;
    logic       own, own_req, own_lock, other_req, forced, beat, rel;
    assign gnt0 = state == OWN0;
    assign gnt1 = state == OWN1;
    assign busy = gnt0 | gnt1 | mem_rd | rvalid0 | rvalid1;
    always_comb begin
        own       = gnt1;
        own_req   = own ? req1 : req0;
        own_lock  = own ? lock1 : lock0;
        other_req = own ? req0 : req1;
        // A forced release must not take a 17th beat in the releasing cycle.
        forced    = (cnt == 5'd16) && other_req;
        beat      = (gnt0 | gnt1) && own_req && !forced;
        rel       = (!own_req && !own_lock) || forced;
        state_nx  = (state == IDLE) ?
                        ((req0 && req1) ? (last_owner ? OWN0 : OWN1) :
                         req0 ? OWN0 : req1 ? OWN1 : IDLE) :
                    ((gnt0 | gnt1) && !rel) ? state : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            cnt        <= 5'd0;
            mem_rd     <= 1'b0;
            mem_addr   <= 14'd0;
            rd_id      <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata      <= 8'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE) begin
                last_owner <= state_nx == OWN1;
                cnt        <= 5'd0;
            end else if (beat && cnt != 5'd16) begin
                cnt <= cnt + 5'd1;
            end
            mem_rd <= beat;
            if (beat) begin
                mem_addr <= own ? addr1 : addr0;
                rd_id    <= own;
            end
            rvalid0 <= mem_rd && !rd_id;
            rvalid1 <= mem_rd && rd_id;
            if (mem_rd)
                rdata <= mem_data;
        end
    end
endmodule

// File: tb/tb_gray_arb.sv
// tb_gray_arb: directed and random stimulus checked against a cycle-history reference model
module tb_gray_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [13:0] addr0 = '0, addr1 = '0;
    logic [7:0]  mem_data = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_rd, busy;
    logic [7:0]  rdata;
    logic [13:0] mem_addr;
    int total = 0;
    int bad = 0;
    gray_arb dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .lock0(lock0), .lock1(lock1),
        .mem_data(mem_data), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .busy(busy)
    );
    always #5 clk = ~clk;
    // Reference: who owns the port, beats taken this ownership, and a per-cycle
    // history of accepted beats and memory data from which outputs are derived.
    int          owner = -1;
    int          last = 1;
    int          beats = 0;
    int          cyc = 2;
    bit          acc [0:4095];
    bit          acc_id [0:4095];
    logic [13:0] acc_addr [0:4095];
    logic [7:0]  md [0:4095];
    logic [13:0] e_addr = '0;
    logic [7:0]  e_rdata = '0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask
    task automatic step(input bit rs, input bit r0, input bit r1, input bit l0, input bit l1,
                        input logic [13:0] a0, input logic [13:0] a1, input logic [7:0] d);
        bit r [2];
        bit l [2];
        logic [13:0] a [2];
        bit e_rv0, e_rv1, e_rd;
        reset = rs; req0 = r0; req1 = r1; lock0 = l0; lock1 = l1;
        addr0 = a0; addr1 = a1; mem_data = d;
        r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1; a[0] = a0; a[1] = a1;
        md[cyc] = d;
        acc[cyc] = 1'b0;
        if (rs) begin
            owner = -1; last = 1; beats = 0;
            acc[cyc-1] = 1'b0;
            e_addr = '0; e_rdata = '0;
        end else if (owner >= 0) begin
            bit forced;
            forced = beats >= 16 && r[1-owner];
            if (r[owner] && !forced) begin
                acc[cyc] = 1'b1; acc_id[cyc] = owner[0]; acc_addr[cyc] = a[owner];
                if (beats < 16) beats++;
            end
            if ((!r[owner] && !l[owner]) || forced) owner = -1;
        end else begin
            if (r0 && r1) owner = 1 - last;
            else if (r0) owner = 0;
            else if (r1) owner = 1;
            if (owner >= 0) begin last = owner; beats = 0; end
        end
        @(posedge clk);
        #1;
        cyc++;
        e_rd  = acc[cyc-1];
        e_rv0 = acc[cyc-2] && !acc_id[cyc-2];
        e_rv1 = acc[cyc-2] && acc_id[cyc-2];
        if (e_rd) e_addr = acc_addr[cyc-1];
        if (e_rv0 || e_rv1) e_rdata = md[cyc-1];
        chk("gnt0", 32'(gnt0), 32'(owner == 0));
        chk("gnt1", 32'(gnt1), 32'(owner == 1));
        chk("mem_rd", 32'(mem_rd), 32'(e_rd));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
        chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
        chk("rdata", 32'(rdata), 32'(e_rdata));
        chk("busy", 32'(busy), 32'(owner >= 0 || e_rd || e_rv0 || e_rv1));
    endtask
    function automatic logic [13:0] ra();
        return 14'($urandom);
    endfunction
    function automatic logic [7:0] rd();
        return 8'($urandom);
    endfunction
    initial begin
        for (int i = 0; i < 4096; i++) begin acc[i] = 1'b0; acc_id[i] = 1'b0; end
        @(negedge clk);
        step(1, 1, 1, 1, 1, ra(), ra(), rd());
        step(1, 0, 0, 0, 0, ra(), ra(), rd());
        // tie after reset goes to requester 0; lock0 with req1 pending forces release at 16 beats
        for (int i = 0; i < 22; i++) step(0, 1, 1, 1, 0, ra(), ra(), rd());
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, ra(), ra(), rd());
        // requester 0 alone for 20 beats, fixed address/data, then drops
        for (int i = 0; i < 21; i++) step(0, 1, 0, 0, 0, 14'h0081, ra(), 8'h5A);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, ra(), ra(), rd());
        // requester 1 owns, then holds only the lock while requester 0 waits
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, ra(), ra(), rd());
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, ra(), ra(), rd());
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, ra(), ra(), rd());
        // reset one cycle after an accepted beat
        step(0, 0, 0, 0, 0, ra(), ra(), rd());
        step(0, 0, 0, 0, 0, ra(), ra(), rd());
        step(0, 1, 0, 0, 0, ra(), ra(), rd());
        step(0, 1, 0, 0, 0, ra(), ra(), rd());
        step(1, 1, 0, 0, 0, ra(), ra(), rd());
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, ra(), ra(), rd());
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ra(), ra(), rd());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
